// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte frame and writes
// little-endian 32-bit words into program memory, holding the core in reset.
//
// Ports:
//   clk         - single clock, rising edge
//   rst_n       - synchronous reset, active HIGH despite the name
//   start       - one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid  - byte_data carries a stream byte
//   byte_data   - incoming stream byte
//   byte_ready  - loader can take a byte (LEN, DATA, CSUM)
//   mem_we      - one-cycle program memory write strobe
//   mem_addr    - byte address of the word being written (4*i)
//   mem_wdata   - assembled instruction word
//   core_rst_n  - core reset, low except in DONE
//   done        - load complete with matching checksum
//   error       - load aborted (oversize length or bad checksum)
//   word_count  - words written in the current load

module prog_loader #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CSUM = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       widx_q, widx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic [31:0]       len_full;
    logic [31:0]       widx_next;

    assign byte_ready = (state_q == LEN) ||
                        (state_q == DATA) ||
                        (state_q == CSUM);
    assign accept     = byte_valid && byte_ready;

    // Length value as it stands once the current byte is the 4th one.
    assign len_full   = {byte_data, len_q[23:0]};
    assign widx_next  = {16'd0, widx_q} + 32'd1;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        len_d   = len_q;
        word_d  = word_q;
        csum_d  = csum_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    bcnt_d  = 2'd0;
                    len_d   = 32'd0;
                    word_d  = 32'd0;
                    csum_d  = 8'd0;
                    widx_d  = 16'd0;
                end
            end
            LEN: begin
                if (accept) begin
                    len_d[{bcnt_q, 3'b000} +: 8] = byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (len_full == 32'd0)
                            state_d = CSUM;
                        else if (len_full > 32'(MAX_WORDS))
                            state_d = ERR;
                        else
                            state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = byte_data;
                    csum_d = csum_q ^ byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Strobe registers update on this edge, so the
                        // write and the new word_count appear together.
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'({widx_q, 2'b00});
                        wdata_d = {byte_data, word_q[23:0]};
                        widx_d  = widx_q + 16'd1;
                        if (widx_next == len_q)
                            state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (byte_data == csum_q)
                        state_d = DONE;
                    else
                        state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= 2'd0;
            len_q   <= 32'd0;
            word_q  <= 32'd0;
            csum_q  <= 8'd0;
            widx_q  <= 16'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = widx_q;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign core_rst_n = (state_q == DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: nominal, bad checksum, empty,
// oversize, gapped stream, gating and mid-load reset scenarios.

module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int n_cmp;
    int n_err;

    logic [31:0] wr_a [0:7];
    logic [31:0] wr_d [0:7];
    int          wr_n;

    logic [7:0]  nom [0:16];
    logic [31:0] exp_a [0:2];
    logic [31:0] exp_d [0:2];

    prog_loader #(
        .ADDR_W    (32),
        .MAX_WORDS (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_n < 8) begin
                wr_a[wr_n] = mem_addr;
                wr_d[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_err++;
            $display("FAIL send_byte: byte_ready=%b after %0d cycles, required 1",
                     byte_ready, guard);
        end
        tick();
    endtask

    task automatic check_writes(input string tag);
        n_cmp++;
        if (wr_n !== 3) begin
            n_err++;
            $display("FAIL %s write_count: got %0d, required 3", tag, wr_n);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== exp_d[i]) begin
                n_err++;
                $display("FAIL %s write%0d: got (%h,%h), required (%h,%h)",
                         tag, i, wr_a[i], wr_d[i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) tick();
        n_cmp++;
        if ({byte_ready, mem_we, core_rst_n, done, error} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {byte_ready, mem_we, core_rst_n, done, error});
        end
        n_cmp++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mem: got (%h,%h), required (0,0)",
                     mem_addr, mem_wdata);
        end
        n_cmp++;
        if (word_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_wc: got %0d, required 0", word_count);
        end
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (byte_ready !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_err++;
            $display("FAIL idle_gating: got ready=%b done=%b err=%b, required 0 0 0",
                     byte_ready, done, error);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_nominal();
        wr_n = 0;
        pulse_start();
        for (int j = 0; j < 17; j++) begin
            send_byte(nom[j]);
            if (j >= 4 && j < 16 && ((j - 4) % 4) == 3) begin
                n_cmp++;
                if (mem_we !== 1'b1 || mem_addr !== exp_a[(j-4)/4] ||
                    mem_wdata !== exp_d[(j-4)/4] ||
                    word_count !== 16'((j-4)/4 + 1) || byte_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL nom_strobe%0d: got we=%b a=%h d=%h wc=%0d rdy=%b, required 1 %h %h %0d 1",
                             (j-4)/4, mem_we, mem_addr, mem_wdata, word_count,
                             byte_ready, exp_a[(j-4)/4], exp_d[(j-4)/4], (j-4)/4 + 1);
                end
            end
        end
        byte_valid = 1'b0;
        tick();
        check_writes("nominal");
        n_cmp++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || error !== 1'b0 ||
            word_count !== 16'd3) begin
            n_err++;
            $display("FAIL nom_final: got done=%b crst=%b err=%b wc=%0d, required 1 1 0 3",
                     done, core_rst_n, error, word_count);
        end
    endtask

    task automatic test_bad_csum();
        wr_n = 0;
        pulse_start();
        n_cmp++;
        if (core_rst_n !== 1'b0 || done !== 1'b0 || word_count !== 16'd0) begin
            n_err++;
            $display("FAIL restart_from_done: got crst=%b done=%b wc=%0d, required 0 0 0",
                     core_rst_n, done, word_count);
        end
        for (int j = 0; j < 16; j++) send_byte(nom[j]);
        send_byte(8'h84);
        byte_valid = 1'b0;
        tick();
        check_writes("badcsum");
        n_cmp++;
        if (error !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL badcsum_final: got err=%b crst=%b done=%b, required 1 0 0",
                     error, core_rst_n, done);
        end
    endtask

    task automatic test_empty();
        wr_n = 0;
        pulse_start();
        for (int j = 0; j < 5; j++) send_byte(8'h00);
        byte_valid = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (wr_n !== 0 || done !== 1'b1 || word_count !== 16'd0 ||
            core_rst_n !== 1'b1) begin
            n_err++;
            $display("FAIL empty: got writes=%0d done=%b wc=%0d crst=%b, required 0 1 0 1",
                     wr_n, done, word_count, core_rst_n);
        end
    endtask

    task automatic test_oversize();
        wr_n = 0;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL oversize_err: got err=%b rdy=%b done=%b, required 1 0 0",
                     error, byte_ready, done);
        end
        byte_data = 8'hAA;
        repeat (3) tick();
        byte_valid = 1'b0;
        n_cmp++;
        if (wr_n !== 0 || error !== 1'b1 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL oversize_hold: got writes=%0d err=%b rdy=%b, required 0 1 0",
                     wr_n, error, byte_ready);
        end
    endtask

    task automatic test_gaps();
        wr_n = 0;
        pulse_start();
        for (int j = 0; j < 17; j++) begin
            byte_valid = 1'b0;
            byte_data  = 8'hEE;
            repeat (j % 3) tick();
            if (j == 9) pulse_start();
            send_byte(nom[j]);
        end
        byte_valid = 1'b0;
        tick();
        check_writes("gaps");
        n_cmp++;
        if (done !== 1'b1 || word_count !== 16'd3) begin
            n_err++;
            $display("FAIL gaps_final: got done=%b wc=%0d, required 1 3",
                     done, word_count);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h13;
        repeat (3) tick();
        n_cmp++;
        if (byte_ready !== 1'b0 || done !== 1'b1 || word_count !== 16'd3 ||
            wr_n !== 3) begin
            n_err++;
            $display("FAIL done_gating: got rdy=%b done=%b wc=%0d writes=%0d, required 0 1 3 3",
                     byte_ready, done, word_count, wr_n);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset_midload();
        wr_n = 0;
        pulse_start();
        for (int j = 0; j < 10; j++) send_byte(nom[j]);
        rst_n      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = nom[10];
        tick();
        n_cmp++;
        if (byte_ready !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || word_count !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_state: got rdy=%b we=%b done=%b err=%b wc=%0d, required 0 0 0 0 0",
                     byte_ready, mem_we, done, error, word_count);
        end
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (wr_n !== 1 || byte_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_stale: got writes=%0d rdy=%b, required 1 0",
                     wr_n, byte_ready);
        end
        wr_n = 0;
        pulse_start();
        for (int j = 0; j < 17; j++) send_byte(nom[j]);
        byte_valid = 1'b0;
        tick();
        check_writes("reload");
        n_cmp++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || word_count !== 16'd3) begin
            n_err++;
            $display("FAIL reload_final: got done=%b crst=%b wc=%0d, required 1 1 3",
                     done, core_rst_n, word_count);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        wr_n       = 0;
        rst_n      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        nom = '{8'h03, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h01, 8'h50, 8'h00,
                8'h13, 8'h02, 8'h20, 8'h00,
                8'hB3, 8'h82, 8'h41, 8'h00,
                8'h83};
        exp_a = '{32'd0, 32'd4, 32'd8};
        exp_d = '{32'h00500193, 32'h00200213, 32'h004182B3};

        test_reset();
        test_nominal();
        test_bad_csum();
        test_empty();
        test_oversize();
        test_gaps();
        test_reset_midload();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of mem_addr.
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning the largest program length accepted, in 32-bit words.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-high reset (asserted = 1, sampled on the clk rising edge).
REQ-005 SHALL have port start, input, 1, one-cycle load request.
REQ-006 SHALL have port byte_valid, input, 1, meaning byte_data is valid.
REQ-007 SHALL have port byte_data, input, 8, the incoming stream byte.
REQ-008 SHALL have port byte_ready, output, 1; a byte is accepted on any cycle where byte_valid and byte_ready are both 1.
REQ-009 SHALL have port mem_we, output, 1, program memory write strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W, the byte address for the program memory write.
REQ-011 SHALL have port mem_wdata, output, 32, the instruction word to write.
REQ-012 SHALL have port core_rst_n, output, 1, active-low reset to the core; 0 holds the core in reset.
REQ-013 SHALL have port done, output, 1, meaning the load completed and the checksum matched.
REQ-014 SHALL have port error, output, 1, meaning the load was aborted.
REQ-015 SHALL have port word_count, output, 16, the number of words written in the current load.

Function
REQ-016 Frame format SHALL be: 4-byte little-endian length N in words, then N words of 4 bytes each, little-endian, then a 1-byte checksum.
REQ-017 The checksum SHALL be the XOR of the 4N data bytes only; the length bytes are excluded.
REQ-018 The state machine SHALL have the states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-019 byte_ready SHALL be 1 in LEN, DATA and CSUM, and 0 in IDLE, DONE and ERR; bytes offered while byte_ready=0 SHALL NOT be consumed.
REQ-020 In IDLE, start=1 SHALL move the FSM to LEN and clear the byte counter, word counter, checksum and word_count.
REQ-021 In DONE or ERR, start=1 SHALL do the same as in IDLE, and core_rst_n SHALL return to 0 on that edge.
REQ-022 start SHALL be ignored in LEN, DATA and CSUM.
REQ-023 LEN SHALL transition on acceptance of the 4th length byte as follows:
- N=0 -> CSUM.
- N>MAX_WORDS -> ERR.
- otherwise -> DATA.
REQ-024 DATA: a byte counter (0..3) SHALL place each accepted byte into word bits [8k+7:8k] and XOR it into the checksum.
REQ-025 On acceptance of the 4th byte of word i, the next cycle SHALL present mem_we=1 for exactly one cycle, with mem_addr=4*i and mem_wdata equal to the assembled word.
REQ-026 word_count SHALL increment in the same cycle that mem_we is asserted.
REQ-027 byte_ready SHALL stay 1 during a write, so back-to-back bytes lose no throughput (1 byte per cycle sustained).
REQ-028 After the write of word N-1 is issued, the FSM SHALL go to CSUM.
REQ-029 CSUM: on an accepted byte equal to the running checksum -> DONE; on any other value -> ERR.
REQ-030 DONE SHALL drive done=1 and core_rst_n=1, held until start or reset.
REQ-031 ERR SHALL drive error=1 and core_rst_n=0, held until start or reset; words already written SHALL NOT be undone.
REQ-032 mem_addr SHALL be a zero-extended 4*i; no wrap is possible because N<=MAX_WORDS.
REQ-033 Idle cycles between bytes (byte_valid=0) SHALL NOT alter any state.

Reset
REQ-034 While rst_n=1, on each clk edge, the FSM SHALL go to IDLE and all counters and the checksum SHALL clear.
REQ-035 Outputs under reset SHALL be: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, done=0, error=0, word_count=0.
REQ-036 Reset SHALL take priority over start and over byte acceptance in the same cycle.
REQ-037 Reset asserted mid-load SHALL abandon the frame; no mem_we SHALL occur from the cycle after reset is sampled.

Verification
REQ-038 Scenario, nominal load: reset, start, then stream 03 00 00 00 | 93 01 50 00 | 13 02 20 00 | B3 82 41 00 | 83 -> writes (0,0x00500193), (4,0x00200213), (8,0x004182B3); then done=1, core_rst_n=1, word_count=3.
REQ-039 Scenario, bad checksum: same stream with checksum 84 -> three writes, then error=1, core_rst_n=0, done=0.
REQ-040 Scenario, empty program: start, then 00 00 00 00 | 00 -> no mem_we, done=1, word_count=0.
REQ-041 Scenario, oversize length: start, then length 0x401 (01 04 00 00) at MAX_WORDS=1024 -> ERR the cycle after the 4th byte, byte_ready=0, no mem_we.
REQ-042 Scenario, gaps and gating: nominal stream with random byte_valid gaps -> identical writes; bytes presented in IDLE or DONE -> byte_ready=0, not consumed.
REQ-043 Scenario, reset mid-load: rst_n=1 after the 6th data byte, then start and the nominal stream -> no stale writes, final result identical to REQ-038.
